// File: rtl/bf_arbiter.sv
// Two-requester front end for one shared pipelined butterfly: one holding slot per requester,
// round-robin issue under a per-requester in-flight limit, results routed back by requester ID.
module bf_arbiter #(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1,
  parameter int MAXOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a_xa,
  input  logic [WIDTH-1:0]  a_xb,
  input  logic [WIDTH-1:0]  a_w,
  input  logic [MWIDTH-1:0] a_m,
  input  logic              a_nd,
  output logic              a_rdy,
  input  logic [WIDTH-1:0]  b_xa,
  input  logic [WIDTH-1:0]  b_xb,
  input  logic [WIDTH-1:0]  b_w,
  input  logic [MWIDTH-1:0] b_m,
  input  logic              b_nd,
  output logic              b_rdy,
  output logic [WIDTH-1:0]  bf_xa,
  output logic [WIDTH-1:0]  bf_xb,
  output logic [WIDTH-1:0]  bf_w,
  output logic [MWIDTH:0]   bf_m_in,
  output logic              bf_x_nd,
  input  logic [WIDTH-1:0]  bf_ya,
  input  logic [WIDTH-1:0]  bf_yb,
  input  logic [MWIDTH:0]   bf_m_out,
  input  logic              bf_y_nd,
  output logic [WIDTH-1:0]  a_ya,
  output logic [WIDTH-1:0]  a_yb,
  output logic [MWIDTH-1:0] a_m_out,
  output logic              a_y_nd,
  output logic [WIDTH-1:0]  b_ya,
  output logic [WIDTH-1:0]  b_yb,
  output logic [MWIDTH-1:0] b_m_out,
  output logic              b_y_nd,
  output logic              error
);

  logic              r_a_full, r_b_full;
  logic [WIDTH-1:0]  r_a_xa, r_a_xb, r_a_w, r_b_xa, r_b_xb, r_b_w;
  logic [MWIDTH-1:0] r_a_m, r_b_m;
  logic [3:0]        r_a_out, r_b_out;
  logic              r_last_b;
  logic [WIDTH-1:0]  r_bf_xa, r_bf_xb, r_bf_w;
  logic [MWIDTH:0]   r_bf_m;
  logic              r_bf_nd;
  logic [WIDTH-1:0]  r_a_ya, r_a_yb, r_b_ya, r_b_yb;
  logic [MWIDTH-1:0] r_a_m_out, r_b_m_out;
  logic              r_a_y_nd, r_b_y_nd, r_err;

  logic w_a_elig, w_b_elig, w_gnt_a, w_gnt_b;
  logic w_ret_a, w_ret_b, w_a_dec, w_b_dec, w_spur;

  assign w_a_elig = r_a_full && (r_a_out < 4'(MAXOUT));
  assign w_b_elig = r_b_full && (r_b_out < 4'(MAXOUT));
  // On a tie the requester that did not win last time goes first.
  assign w_gnt_a  = w_a_elig && (!w_b_elig || r_last_b);
  assign w_gnt_b  = w_b_elig && (!w_a_elig || !r_last_b);

  assign w_ret_a  = bf_y_nd && !bf_m_out[MWIDTH];
  assign w_ret_b  = bf_y_nd &&  bf_m_out[MWIDTH];
  // A result with nothing outstanding is still delivered, but never wraps the counter.
  assign w_a_dec  = w_ret_a && (r_a_out != 4'd0);
  assign w_b_dec  = w_ret_b && (r_b_out != 4'd0);
  assign w_spur   = (w_ret_a && (r_a_out == 4'd0)) || (w_ret_b && (r_b_out == 4'd0));

  assign a_rdy = !r_a_full;
  assign b_rdy = !r_b_full;

  always_ff @(posedge clk) begin
    if (!rst && a_nd && !r_a_full) begin
      r_a_xa <= a_xa;
      r_a_xb <= a_xb;
      r_a_w  <= a_w;
      r_a_m  <= a_m;
    end
    if (!rst && b_nd && !r_b_full) begin
      r_b_xa <= b_xa;
      r_b_xb <= b_xb;
      r_b_w  <= b_w;
      r_b_m  <= b_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_full  <= 1'b0;
      r_b_full  <= 1'b0;
      r_a_out   <= 4'd0;
      r_b_out   <= 4'd0;
      r_last_b  <= 1'b1;
      r_bf_xa   <= '0;
      r_bf_xb   <= '0;
      r_bf_w    <= '0;
      r_bf_m    <= '0;
      r_bf_nd   <= 1'b0;
      r_a_ya    <= '0;
      r_a_yb    <= '0;
      r_a_m_out <= '0;
      r_a_y_nd  <= 1'b0;
      r_b_ya    <= '0;
      r_b_yb    <= '0;
      r_b_m_out <= '0;
      r_b_y_nd  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (a_nd && !r_a_full)  r_a_full <= 1'b1;
      else if (w_gnt_a)       r_a_full <= 1'b0;
      if (b_nd && !r_b_full)  r_b_full <= 1'b1;
      else if (w_gnt_b)       r_b_full <= 1'b0;

      r_bf_nd <= w_gnt_a || w_gnt_b;
      if (w_gnt_a) begin
        r_bf_xa  <= r_a_xa;
        r_bf_xb  <= r_a_xb;
        r_bf_w   <= r_a_w;
        r_bf_m   <= {1'b0, r_a_m};
        r_last_b <= 1'b0;
      end else if (w_gnt_b) begin
        r_bf_xa  <= r_b_xa;
        r_bf_xb  <= r_b_xb;
        r_bf_w   <= r_b_w;
        r_bf_m   <= {1'b1, r_b_m};
        r_last_b <= 1'b1;
      end

      r_a_out <= r_a_out + {3'b0, w_gnt_a && !w_a_dec} - {3'b0, w_a_dec && !w_gnt_a};
      r_b_out <= r_b_out + {3'b0, w_gnt_b && !w_b_dec} - {3'b0, w_b_dec && !w_gnt_b};

      r_a_y_nd <= w_ret_a;
      r_b_y_nd <= w_ret_b;
      if (w_ret_a) begin
        r_a_ya    <= bf_ya;
        r_a_yb    <= bf_yb;
        r_a_m_out <= bf_m_out[MWIDTH-1:0];
      end
      if (w_ret_b) begin
        r_b_ya    <= bf_ya;
        r_b_yb    <= bf_yb;
        r_b_m_out <= bf_m_out[MWIDTH-1:0];
      end
      r_err <= w_spur;
    end
  end

  assign bf_xa   = r_bf_xa;
  assign bf_xb   = r_bf_xb;
  assign bf_w    = r_bf_w;
  assign bf_m_in = r_bf_m;
  assign bf_x_nd = r_bf_nd;
  assign a_ya    = r_a_ya;
  assign a_yb    = r_a_yb;
  assign a_m_out = r_a_m_out;
  assign a_y_nd  = r_a_y_nd;
  assign b_ya    = r_b_ya;
  assign b_yb    = r_b_yb;
  assign b_m_out = r_b_m_out;
  assign b_y_nd  = r_b_y_nd;
  assign error   = r_err;

endmodule

// File: tb/tb_bf_arbiter.sv
// Bench for bf_arbiter: transaction-level reference model feeds expectation queues,
// a negedge monitor pops and compares; a butterfly model returns issued ops.
module tb_bf_arbiter;
  localparam int W = 32;
  localparam int MW = 1;
  localparam int MAXOUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] a_xa = '0, a_xb = '0, a_w = '0, b_xa = '0, b_xb = '0, b_w = '0;
  logic [MW-1:0] a_m = '0, b_m = '0;
  logic a_nd = 1'b0, b_nd = 1'b0;
  logic a_rdy, b_rdy;
  logic [W-1:0] bf_xa, bf_xb, bf_w;
  logic [MW:0] bf_m_in;
  logic bf_x_nd;
  logic [W-1:0] bf_ya = '0, bf_yb = '0;
  logic [MW:0] bf_m_out = '0;
  logic bf_y_nd = 1'b0;
  logic [W-1:0] a_ya, a_yb, b_ya, b_yb;
  logic [MW-1:0] a_m_out, b_m_out;
  logic a_y_nd, b_y_nd, error;

  bf_arbiter #(.WIDTH(W), .MWIDTH(MW), .MAXOUT(MAXOUT)) dut (
    .clk(clk), .rst(rst),
    .a_xa(a_xa), .a_xb(a_xb), .a_w(a_w), .a_m(a_m), .a_nd(a_nd), .a_rdy(a_rdy),
    .b_xa(b_xa), .b_xb(b_xb), .b_w(b_w), .b_m(b_m), .b_nd(b_nd), .b_rdy(b_rdy),
    .bf_xa(bf_xa), .bf_xb(bf_xb), .bf_w(bf_w), .bf_m_in(bf_m_in), .bf_x_nd(bf_x_nd),
    .bf_ya(bf_ya), .bf_yb(bf_yb), .bf_m_out(bf_m_out), .bf_y_nd(bf_y_nd),
    .a_ya(a_ya), .a_yb(a_yb), .a_m_out(a_m_out), .a_y_nd(a_y_nd),
    .b_ya(b_ya), .b_yb(b_yb), .b_m_out(b_m_out), .b_y_nd(b_y_nd),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; logic [W-1:0] xa, xb, w; logic [MW:0] m; } iss_t;
  typedef struct { int stamp; logic [W-1:0] ya, yb; logic [MW-1:0] m; } res_t;
  typedef struct { int stamp; logic [W-1:0] ya, yb; logic [MW:0] m; } ret_t;

  iss_t iss_q[$];
  res_t ra_q[$], rb_q[$];
  ret_t pipe[$];
  int err_q[$], rst_q[$];

  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  bit bfly_auto = 1'b0;
  int lat = 2;

  // Reference model state: one slot per requester, in-flight counts, last winner.
  logic hf[2];
  logic [W-1:0] hxa[2], hxb[2], hw[2];
  logic [MW-1:0] hm[2];
  int outs[2];
  int last = 1;

  logic [3*W+MW:0] last_iss = '0;
  logic [2*W+MW-1:0] last_ra = '0, last_rb = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic cap[2];
    logic elig[2];
    int g;
    int id;
    res_t r;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin hf[i] = 1'b0; outs[i] = 0; end
      last = 1;
      rst_q.push_back(cyc);
      return;
    end
    cap[0] = a_nd && !hf[0];
    cap[1] = b_nd && !hf[1];
    for (int i = 0; i < 2; i++) elig[i] = hf[i] && (outs[i] < MAXOUT);
    if (bf_y_nd) begin
      id = int'(bf_m_out[MW]);
      r = '{cyc, bf_ya, bf_yb, bf_m_out[MW-1:0]};
      if (id == 0) ra_q.push_back(r); else rb_q.push_back(r);
      if (outs[id] == 0) err_q.push_back(cyc); else outs[id]--;
    end
    g = -1;
    if (elig[0] && elig[1]) g = 1 - last;
    else if (elig[0]) g = 0;
    else if (elig[1]) g = 1;
    if (g >= 0) begin
      iss_q.push_back('{cyc, hxa[g], hxb[g], hw[g], {(g == 1), hm[g]}});
      hf[g] = 1'b0;
      outs[g]++;
      last = g;
    end
    if (cap[0]) begin hf[0] = 1'b1; hxa[0] = a_xa; hxb[0] = a_xb; hw[0] = a_w; hm[0] = a_m; end
    if (cap[1]) begin hf[1] = 1'b1; hxa[1] = b_xa; hxb[1] = b_xb; hw[1] = b_w; hm[1] = b_m; end
  endtask

  task automatic monitor_step();
    iss_t e;
    res_t r;
    bit ex;
    if (rst_q.size() > 0 && rst_q[0] == cyc) begin
      void'(rst_q.pop_front());
      last_iss = '0; last_ra = '0; last_rb = '0;
    end
    chk("a_rdy", 128'(a_rdy), 128'(!hf[0]));
    chk("b_rdy", 128'(b_rdy), 128'(!hf[1]));
    if (iss_q.size() > 0 && iss_q[0].stamp == cyc) begin
      e = iss_q.pop_front();
      last_iss = {e.xa, e.xb, e.w, e.m};
      chk("issue_nd", 128'(bf_x_nd), 128'(1));
    end else chk("no_issue", 128'(bf_x_nd), 128'(0));
    chk("issue_data", 128'({bf_xa, bf_xb, bf_w, bf_m_in}), 128'(last_iss));
    if (ra_q.size() > 0 && ra_q[0].stamp == cyc) begin
      r = ra_q.pop_front();
      last_ra = {r.ya, r.yb, r.m};
      chk("a_y_nd", 128'(a_y_nd), 128'(1));
    end else chk("a_y_nd_idle", 128'(a_y_nd), 128'(0));
    chk("a_result", 128'({a_ya, a_yb, a_m_out}), 128'(last_ra));
    if (rb_q.size() > 0 && rb_q[0].stamp == cyc) begin
      r = rb_q.pop_front();
      last_rb = {r.ya, r.yb, r.m};
      chk("b_y_nd", 128'(b_y_nd), 128'(1));
    end else chk("b_y_nd_idle", 128'(b_y_nd), 128'(0));
    chk("b_result", 128'({b_ya, b_yb, b_m_out}), 128'(last_rb));
    ex = (err_q.size() > 0 && err_q[0] == cyc);
    if (ex) void'(err_q.pop_front());
    chk("error", 128'(error), 128'(ex));
  endtask

  // Pipelined butterfly: issued ops come back after lat cycles; idle lines carry noise.
  task automatic bfly_step();
    bit hit = 1'b0;
    bf_y_nd = 1'b0;
    bf_ya = $urandom; bf_yb = $urandom; bf_m_out = MW'($urandom) + '0;
    for (int i = 0; i < pipe.size(); i++) begin
      if (pipe[i].stamp == cyc && !hit) begin
        bf_y_nd = 1'b1; bf_ya = pipe[i].ya; bf_yb = pipe[i].yb; bf_m_out = pipe[i].m;
        pipe.delete(i);
        hit = 1'b1;
      end
    end
    if (bfly_auto && bf_x_nd) pipe.push_back('{cyc + lat, bf_xa + bf_w, bf_xb - bf_w, bf_m_in});
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); if (cyc > 0) monitor_step(); bfly_step(); end

  task automatic tick(input int n); repeat (n) @(negedge clk); endtask

  task automatic inject(input bit id, input logic [W-1:0] ya, input logic [MW-1:0] m);
    pipe.push_back('{cyc + 1, ya, ~ya, {id, m}});
  endtask

  task automatic do_reset();
    bfly_auto = 1'b0;
    rst = 1'b1; a_nd = 1'b1; b_nd = 1'b1;
    inject(1'b0, 32'h77, '0);
    tick(2);
    rst = 1'b0; a_nd = 1'b0; b_nd = 1'b0;
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: run exceeded time limit at cyc %0d", cyc);
    finish_up();
  end

  initial begin
    int lats[3];
    bit exp_id;
    lats = '{1, 3, 6};
    tick(3);
    rst = 1'b0;
    tick(1);

    // Tie straight after reset: A first, then B.
    a_nd = 1'b1; a_xa = 32'd1; b_nd = 1'b1; b_xa = 32'd2;
    tick(1);
    a_nd = 1'b0; b_nd = 1'b0;
    tick(1);
    chk("tie_first", 128'({bf_x_nd, bf_m_in[MW], bf_xa}), 128'({1'b1, 1'b0, 32'd1}));
    tick(1);
    chk("tie_second", 128'({bf_x_nd, bf_m_in[MW], bf_xa}), 128'({1'b1, 1'b1, 32'd2}));
    tick(3);

    // Routing of a legitimate B result.
    do_reset();
    b_nd = 1'b1; b_xa = 32'd7; b_m = '0;
    tick(1);
    b_nd = 1'b0;
    tick(2);
    inject(1'b1, 32'd5, 1'b1);
    tick(2);
    chk("route_b", 128'({b_y_nd, b_ya, b_m_out, a_y_nd, error}), 128'({1'b1, 32'd5, 1'b1, 1'b0, 1'b0}));
    tick(2);

    // In-flight limit: third A op waits until one result returns.
    do_reset();
    a_nd = 1'b1;
    for (int i = 0; i < 6; i++) begin a_xa = $urandom; a_xb = $urandom; a_w = $urandom; tick(1); end
    a_nd = 1'b0;
    tick(3);
    chk("limit_rdy", 128'(a_rdy), 128'(0));
    chk("limit_hold", 128'(bf_x_nd), 128'(0));
    inject(1'b0, 32'h11, '0);
    tick(2);
    chk("limit_wait", 128'(bf_x_nd), 128'(0));
    tick(1);
    chk("limit_release", 128'({bf_x_nd, bf_m_in[MW]}), 128'({1'b1, 1'b0}));
    tick(2);

    // Spurious A return: error, still routed, counter stays at zero.
    do_reset();
    inject(1'b0, 32'd9, '0);
    tick(2);
    chk("spur", 128'({error, a_y_nd, b_y_nd}), 128'(3'b110));
    inject(1'b0, 32'd10, '0);
    tick(2);
    chk("spur_again", 128'(error), 128'(1));
    tick(2);

    // Reset with one op outstanding and one held.
    do_reset();
    a_nd = 1'b1; a_xa = 32'hA1;
    tick(1);
    a_nd = 1'b0;
    tick(1);
    a_nd = 1'b1; a_xa = 32'hA2;
    tick(1);
    a_nd = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("rst_mid_rdy", 128'(a_rdy), 128'(1));
    tick(3);
    inject(1'b0, 32'hA1, '0);
    tick(2);
    chk("late_result_err", 128'(error), 128'(1));
    tick(2);

    // Fairness under continuous demand from both sides.
    do_reset();
    bfly_auto = 1'b1; lat = 2; exp_id = 1'b0;
    a_nd = 1'b1; b_nd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_xa = $urandom; b_xa = $urandom; a_m = MW'($urandom); b_m = MW'($urandom);
      tick(1);
      if (bf_x_nd) begin
        chk("fair_alt", 128'(bf_m_in[MW]), 128'(exp_id));
        exp_id = !exp_id;
      end
    end
    a_nd = 1'b0; b_nd = 1'b0;
    tick(10);

    // Random traffic at several butterfly latencies.
    foreach (lats[k]) begin
      lat = lats[k];
      bfly_auto = 1'b1;
      for (int c = 0; c < 300; c++) begin
        a_nd = ($urandom_range(0, 3) != 0); b_nd = ($urandom_range(0, 2) != 0);
        a_xa = $urandom; a_xb = $urandom; a_w = $urandom; a_m = MW'($urandom);
        b_xa = $urandom; b_xb = $urandom; b_w = $urandom; b_m = MW'($urandom);
        tick(1);
      end
      a_nd = 1'b0; b_nd = 1'b0;
      tick(14);
    end
    finish_up();
  end
endmodule

// File: doc/bf_arbiter.md
BF_ARBITER -- requirements
Module: bf_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, width of each complex word (xa, xb, w, ya, yb).
REQ-002 Parameter MWIDTH, default 1, width of per-operation metadata carried alongside each butterfly.
REQ-003 Parameter MAXOUT, default 8, range 1-15, maximum butterflies in flight per requester.
REQ-004 Ports, in this order:
- clk  in  1  clock; everything is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- a_xa, a_xb, a_w  in  WIDTH each  requester A operands.
- a_m  in  MWIDTH  requester A metadata.
- a_nd  in  1  requester A offers an operation.
- a_rdy  out  1  requester A holding slot is free.
- b_xa, b_xb, b_w, b_m, b_nd, b_rdy: same for requester B.
- bf_xa, bf_xb, bf_w  out  WIDTH each  operands to the shared butterfly.
- bf_m_in  out  MWIDTH+1  metadata to the butterfly; MSB is the requester ID (0=A, 1=B).
- bf_x_nd  out  1  issue strobe to the butterfly.
- bf_ya, bf_yb  in  WIDTH each  butterfly results.
- bf_m_out  in  MWIDTH+1  returned metadata.
- bf_y_nd  in  1  result strobe.
- a_ya, a_yb  out  WIDTH each  results routed to A.
- a_m_out  out  MWIDTH  metadata routed to A.
- a_y_nd  out  1  result strobe to A.
- b_ya, b_yb, b_m_out, b_y_nd: same for requester B.
- error  out  1  protocol error pulse.

Function
REQ-005 Each requester has a one-entry holding register (xa, xb, w, m, full flag).
REQ-006 a_rdy SHALL equal ~full_A combinationally, with no bypass; b_rdy likewise for B.
REQ-007 When a_nd & a_rdy at a clock edge, the A operands SHALL be captured and full_A set; a_nd while ~a_rdy is ignored (dropped). B likewise.
REQ-008 Requester X is eligible when full_X is set and outstanding_X < MAXOUT.
REQ-009 Each cycle, at most one eligible requester SHALL be granted.
- Only one requester eligible: it is granted.
- Both eligible: the requester not granted most recently wins (round-robin).
REQ-010 On a grant, at the next edge:
- bf_xa/bf_xb/bf_w take the granted entry.
- bf_m_in = {ID, m}.
- bf_x_nd = 1 for exactly one cycle.
- the granted full flag clears, so rdy rises the cycle after issue.
REQ-011 Issue latency: operands captured at edge N give bf_x_nd high during cycle N+1 at the earliest.
REQ-012 With no grant, bf_x_nd SHALL be 0; bf_xa/xb/w/m_in hold their last values.
REQ-013 The butterfly is fully pipelined and accepts bf_x_nd on consecutive cycles.
- Sustained throughput is 1 op/cycle with both requesters active.
- A single requester alone is limited to 1 op per 2 cycles.
REQ-014 outstanding_X (4-bit counter):
- +1 on issue to X.
- -1 when bf_y_nd arrives with ID=X.
- Unchanged when both happen in the same cycle.
REQ-015 On bf_y_nd, the result SHALL be registered to the port selected by bf_m_out[MWIDTH]:
- {x_ya, x_yb, x_m_out} = {bf_ya, bf_yb, bf_m_out[MWIDTH-1:0]}.
- x_y_nd pulses one cycle later (latency 1); the other requester's y_nd stays 0.
REQ-016 Result ports SHALL hold their values when y_nd is low.
REQ-017 A bf_y_nd whose ID requester has outstanding = 0:
- error SHALL pulse for one cycle.
- The result SHALL still be routed.
- The counter SHALL NOT decrement (no wrap).
REQ-018 error SHALL otherwise be 0; it is a registered, single-cycle pulse per offending result.

Reset
REQ-019 While rst is high, at each edge:
- full_A and full_B clear; outstanding counters clear.
- bf_x_nd, a_y_nd, b_y_nd and error are 0.
- All data and metadata outputs are 0.
- Last-grant is set to B, so A wins the first tie.
REQ-020 Reset mid-operation SHALL discard held entries; a_nd/b_nd and bf_y_nd are ignored while rst is high.
REQ-021 Results returning after reset for pre-reset issues SHALL be treated per REQ-017 (error pulse).
REQ-022 a_rdy and b_rdy SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-023 Tie: after reset, a_nd and b_nd offered in the same cycle with a_xa=1, b_xa=2 -> bf_x_nd in two consecutive cycles; bf_xa=1 with bf_m_in MSB 0, then bf_xa=2 with MSB 1.
REQ-024 Fairness: a_nd and b_nd held high continuously for 20 cycles -> issues alternate A,B,A,B; no requester is granted twice in a row while the other is eligible.
REQ-025 Routing: bf_y_nd with bf_m_out={1,m=1}, bf_ya=5 -> next cycle b_y_nd=1, b_ya=5, b_m_out=1; a_y_nd=0; error=0.
REQ-026 Limit: MAXOUT=2, A issues 2 ops with no returns -> a third held A op is not issued and a_rdy stays 0; after one A result returns, the op issues the following cycle.
REQ-027 Spurious return: bf_y_nd with ID=A while outstanding_A=0 -> error high for exactly one cycle, a_y_nd=1, and outstanding_A remains 0.
REQ-028 Reset mid-op: A entry held and 1 op outstanding, rst pulsed 1 cycle -> a_rdy=1 and no bf_x_nd afterwards; the late A result returning gives error=1.
